// File: rtl/sfp_pkg.sv
// rtl/sfp_pkg.sv - shared types, layout constants and helpers for the SFP frame handler
package sfp_pkg;

   localparam int SFP_WORD_W = 32;

   // Frame lengths include the trailing checksum word
   localparam int N_WORDS_MASTER = 12 + 1;
   localparam int N_WORDS_SLAVE  = 37 + 1;

   typedef enum logic [2:0] {
      T_IDLE = 3'd0,
      T_EN   = 3'd1,
      T_RUN  = 3'd2,
      T_WAIT = 3'd3,
      T_HOLD = 3'd4
   } tx_state_t;

   typedef enum logic [1:0] {
      R_IDLE   = 2'd0,
      R_CHECK  = 2'd1,
      R_COMMIT = 2'd2
   } rx_state_t;

   // Named word indices so readers address the active bank symbolically
   localparam int set_c         = 0;
   localparam int p_gain_c      = 1;
   localparam int i_gain_c      = 2;
   localparam int d_gain_c      = 3;
   localparam int cksum_master_c = N_WORDS_MASTER - 1;
   localparam int cksum_slave_c  = N_WORDS_SLAVE - 1;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/sfp_tx_sched.sv
// rtl/sfp_tx_sched.sv - periodic SFP transmit scheduler with hold gap and tx-end watchdog
module sfp_tx_sched
   import sfp_pkg::*;
#(
   parameter int HOLD_CYCLES    = 1024,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_sfp_en,
   input  logic       i_tx_end_flag,
   output logic       o_tx_start_flag,
   output logic       o_timeout,
   output logic [2:0] o_tx_state
);

   localparam int MAXC = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   tx_state_t       r_state, w_next;
   logic [CW-1:0]   r_cnt, w_cnt_next;
   logic            r_timeout, w_timeout_next;
   logic            r_start;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state   <= T_IDLE;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
         r_start   <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_cnt     <= w_cnt_next;
         r_timeout <= w_timeout_next;
         r_start   <= (r_state == T_RUN) && i_sfp_en;
      end
   end

   // One counter serves both the wait watchdog and the hold gap
   always_comb begin
      w_next         = r_state;
      w_cnt_next     = r_cnt;
      w_timeout_next = r_timeout;
      if (!i_sfp_en) begin
         w_next         = T_IDLE;
         w_cnt_next     = '0;
         w_timeout_next = 1'b0;
      end else begin
         case (r_state)
            T_IDLE: w_next = T_EN;
            T_EN:   w_next = T_RUN;
            T_RUN: begin
               w_next     = T_WAIT;
               w_cnt_next = '0;
            end
            T_WAIT: begin
               if (i_tx_end_flag) begin
                  w_next     = T_HOLD;
                  w_cnt_next = '0;
               end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  w_next         = T_HOLD;
                  w_cnt_next     = '0;
                  w_timeout_next = 1'b1;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
            T_HOLD: begin
               if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
                  w_next     = T_EN;
                  w_cnt_next = '0;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
            default: w_next = T_IDLE;
         endcase
      end
   end

   assign o_tx_start_flag = r_start;
   assign o_timeout       = r_timeout;
   assign o_tx_state      = r_state;

endmodule

// File: rtl/sfp_frame_handler.sv
// rtl/sfp_frame_handler.sv - SFP frame capture, multi-cycle XOR check, atomic commit and read port
module sfp_frame_handler
   import sfp_pkg::*;
#(
   parameter int N_WORDS        = 38,
   parameter int HOLD_CYCLES    = 1024,
   parameter int TIMEOUT_CYCLES = 65536,
   parameter int AW             = $clog2(N_WORDS)
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_sfp_en,
   input  logic                          i_slave,
   input  logic [N_WORDS*SFP_WORD_W-1:0] i_rx_data,
   input  logic                          i_rx_end_flag,
   input  logic                          i_tx_end_flag,
   output logic                          o_tx_start_flag,
   input  logic [AW-1:0]                 i_rd_addr,
   output logic [SFP_WORD_W-1:0]         o_rd_data,
   output logic                          o_frame_valid,
   output logic                          o_commit,
   output logic [15:0]                   o_rx_cnt,
   output logic [15:0]                   o_crc_err_cnt,
   output logic [15:0]                   o_ovr_cnt,
   output logic                          o_timeout,
   output logic                          o_mode,
   output logic [2:0]                    o_tx_state,
   output logic [1:0]                    o_rx_state
);

   sfp_tx_sched #(
      .HOLD_CYCLES    (HOLD_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_tx_sched (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_sfp_en        (i_sfp_en),
      .i_tx_end_flag   (i_tx_end_flag),
      .o_tx_start_flag (o_tx_start_flag),
      .o_timeout       (o_timeout),
      .o_tx_state      (o_tx_state)
   );

   rx_state_t              r_rx_state, w_rx_next;
   logic [SFP_WORD_W-1:0]  r_shadow [N_WORDS];
   logic [SFP_WORD_W-1:0]  r_active [N_WORDS];
   logic [SFP_WORD_W-1:0]  r_acc;
   logic [AW-1:0]          r_idx;
   logic [SFP_WORD_W-1:0]  r_rd_data;
   logic [15:0]            r_rx_cnt, r_crc_err_cnt, r_ovr_cnt;
   logic                   r_frame_valid, r_mode;
   logic                   w_last, w_match, w_rd_ok;

   assign w_last  = (r_idx == AW'(N_WORDS - 1));
   assign w_match = (r_acc == r_shadow[N_WORDS-1]);
   assign w_rd_ok = ({1'b0, i_rd_addr} < (AW+1)'(N_WORDS));

   always_comb begin
      w_rx_next = r_rx_state;
      case (r_rx_state)
         R_IDLE:   if (i_rx_end_flag) w_rx_next = R_CHECK;
         R_CHECK:  if (w_last) w_rx_next = w_match ? R_COMMIT : R_IDLE;
         R_COMMIT: w_rx_next = R_IDLE;
         default:  w_rx_next = R_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_rx_state    <= R_IDLE;
         r_acc         <= '0;
         r_idx         <= '0;
         r_rd_data     <= '0;
         r_rx_cnt      <= '0;
         r_crc_err_cnt <= '0;
         r_ovr_cnt     <= '0;
         r_frame_valid <= 1'b0;
         r_mode        <= 1'b0;
         for (int k = 0; k < N_WORDS; k++) begin
            r_shadow[k] <= '0;
            r_active[k] <= '0;
         end
      end else begin
         r_rx_state <= w_rx_next;
         r_mode     <= i_slave;
         r_rd_data  <= w_rd_ok ? r_active[i_rd_addr] : '0;
         // Frames arriving while a check or commit is in flight are dropped
         if (i_rx_end_flag && (r_rx_state != R_IDLE))
            r_ovr_cnt <= sat_inc(r_ovr_cnt);
         case (r_rx_state)
            R_IDLE: begin
               if (i_rx_end_flag) begin
                  for (int k = 0; k < N_WORDS; k++)
                     r_shadow[k] <= i_rx_data[k*SFP_WORD_W +: SFP_WORD_W];
                  r_acc <= '0;
                  r_idx <= '0;
               end
            end
            R_CHECK: begin
               if (!w_last) begin
                  r_acc <= r_acc ^ r_shadow[r_idx];
                  r_idx <= r_idx + 1'b1;
               end else if (!w_match) begin
                  r_crc_err_cnt <= sat_inc(r_crc_err_cnt);
               end
            end
            R_COMMIT: begin
               for (int k = 0; k < N_WORDS; k++)
                  r_active[k] <= r_shadow[k];
               r_rx_cnt      <= sat_inc(r_rx_cnt);
               r_frame_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_commit      = (r_rx_state == R_COMMIT);
   assign o_rd_data     = r_rd_data;
   assign o_frame_valid = r_frame_valid;
   assign o_rx_cnt      = r_rx_cnt;
   assign o_crc_err_cnt = r_crc_err_cnt;
   assign o_ovr_cnt     = r_ovr_cnt;
   assign o_mode        = r_mode;
   assign o_rx_state    = r_rx_state;

endmodule

// File: doc/sfp_frame_handler.md
Name: sfp_frame_handler

Overview:
- Parametrised successor to the fixed-layout SFP handler.
- Runs the periodic SFP transmit cadence with a configurable hold gap and a tx-end watchdog.
- Captures received frames of N_WORDS 32-bit words, checks an XOR checksum over several cycles, and commits good frames atomically to an active register bank.
- Downstream MPS logic reads committed words through a word-addressed read port. Mode (master/slave) is a port, not a build option, so one netlist serves both roles.

Parameters:
- N_WORDS, 38, words per frame including the checksum word (minimum 2).
- HOLD_CYCLES, 1024, idle cycles between tx_end and the next tx start.
- TIMEOUT_CYCLES, 65536, maximum cycles in TX_WAIT before the watchdog fires.
- AW, $clog2(N_WORDS), read address width.

Ports:
- i_clk, in, 1, system clock.
- i_rst, in, 1, reset: asynchronous, active-low.
- i_sfp_en, in, 1, Zynq enable; low forces both FSMs to idle.
- i_slave, in, 1, 1 = slave (accepts frames), 0 = master (accepts frames too; mode is reported only).
- i_rx_data, in, N_WORDS*32, received frame; word k = bits [32k+31:32k].
- i_rx_end_flag, in, 1, one-cycle pulse; i_rx_data valid in that cycle.
- i_tx_end_flag, in, 1, one-cycle pulse from the transmitter.
- o_tx_start_flag, out, 1, one-cycle transmit request.
- i_rd_addr, in, AW, word index into the active bank.
- o_rd_data, out, 32, registered active-bank word.
- o_frame_valid, out, 1, sticky; set after the first good commit.
- o_commit, out, 1, one-cycle pulse on each commit.
- o_rx_cnt, out, 16, good frames (saturating).
- o_crc_err_cnt, out, 16, checksum failures (saturating).
- o_ovr_cnt, out, 16, frames dropped while busy (saturating).
- o_timeout, out, 1, sticky watchdog flag.
- o_mode, out, 1, registered i_slave.
- o_tx_state, out, 3, TX FSM state encoding.
- o_rx_state, out, 2, RX FSM state encoding.

Behaviour:
- Reset: every output, register, counter and bank word is 0. Reset is asynchronous mid-operation; no partial commit survives it.
- TX FSM encodings: T_IDLE=0, T_EN=1, T_RUN=2, T_WAIT=3, T_HOLD=4.
  - T_IDLE -> T_EN when i_sfp_en = 1.
  - T_EN -> T_RUN unconditionally.
  - T_RUN -> T_WAIT; o_tx_start_flag is high for exactly the cycle after T_RUN (registered).
  - T_WAIT -> T_HOLD on i_tx_end_flag. If the wait counter reaches TIMEOUT_CYCLES-1 first, set o_timeout and go to T_HOLD.
  - T_HOLD counts HOLD_CYCLES cycles, then -> T_EN.
  - i_sfp_en = 0 in any state -> T_IDLE next cycle and clears o_timeout.
  - A tx_end pulse outside T_WAIT is ignored.
- RX FSM encodings: R_IDLE=0, R_CHECK=1, R_COMMIT=2. It runs regardless of i_sfp_en.
  - R_IDLE: on i_rx_end_flag, latch i_rx_data into the shadow buffer, clear the accumulator and index, go to R_CHECK.
  - R_CHECK: one word per cycle, acc ^= shadow[idx] for idx = 0..N_WORDS-2, giving N_WORDS-1 cycles. Then compare acc against shadow[N_WORDS-1]. On match go to R_COMMIT. On mismatch increment o_crc_err_cnt and go to R_IDLE.
  - R_COMMIT: copy the whole shadow buffer to the active bank in one cycle, pulse o_commit, set o_frame_valid, increment o_rx_cnt, go to R_IDLE.
  - Frame-in to o_commit latency is N_WORDS+1 cycles.
- An i_rx_end_flag arriving in R_CHECK or R_COMMIT is dropped and o_ovr_cnt increments. The shadow buffer is not disturbed.
- o_rd_data = active[i_rd_addr], registered, 1-cycle latency.
- An address >= N_WORDS returns 0. A read in the commit cycle returns the old data; the next cycle returns the new data.
- All counters stick at 16'hFFFF.
- o_mode updates every cycle. A mode change never aborts a check in progress.

Decomposition:
- Shared package sfp_pkg:
  - TX/RX state localparams.
  - SFP_WORD_W = 32.
  - Default N_WORDS values for the master (12+1) and slave (37+1) layouts.
  - Word-index constants for the named fields (set_c, p_gain_c, ...) so consumers use i_rd_addr symbolically.
- Sub-module sfp_tx_sched holds the TX FSM, hold counter and watchdog. The top holds the RX checker, buffers and read port.

Test Plan:
- Enable with N_WORDS=4, HOLD_CYCLES=8 and pulse tx_end 3 cycles after each start -> starts 1+3+8+2 = 14 cycles apart, o_timeout stays 0.
- Frame {1,2,4,7} (7 = 1^2^4) -> o_commit 5 cycles after rx_end; o_rx_cnt = 1; reading addr 2 gives 4 one cycle later.
- Frame {1,2,4,6} -> o_crc_err_cnt = 1, active bank unchanged, no o_commit.
- Second rx_end 2 cycles after the first -> o_ovr_cnt = 1; the first frame still commits correctly.
- No tx_end with TIMEOUT_CYCLES=16 -> o_timeout = 1 after 16 cycles in T_WAIT. Dropping i_sfp_en clears it and gives o_tx_state = 0.
- Assert i_rst low during R_CHECK -> all counters and bank words are 0, and o_frame_valid = 0.
